circuit_eval: RTL and testbench

//  Downstream evaluator for an evolved combinational circuit (2-bit in, 1-bit out).

---
 rtl/circuit_eval_pkg.sv | 14 +
 rtl/circuit_eval_sync_2ff.sv | 22 ++
 rtl/circuit_eval.sv | 138 +++++++++++++
 tb/tb_circuit_eval.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/circuit_eval_pkg.sv
// circuit_eval_pkg: shared state encoding and vector constants for the circuit evaluator
package circuit_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W = 2;

endpackage

// File: rtl/circuit_eval_sync_2ff.sv
// sync_2ff: two-flop synchroniser bringing the asynchronous evolved-circuit output into clk
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the raw input through two flops, both cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/circuit_eval.sv
// circuit_eval: drives all four input vectors into an evolved 2-in/1-out circuit, samples its
// synchronised output, records truth table and instability, reports pass/fail.
// Optional toggle counter enabled by defining CIRCUIT_EVAL_TOGGLE_CNT_EN.
module circuit_eval
    import circuit_eval_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic [VEC_W-1:0]       dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] result,
    output logic [NUM_VECTORS-1:0] unstable,
    output logic                   pass,
    output logic [CNT_W-1:0]       toggle_count
);

    localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    if (SETTLE_CYCLES < 3) begin : g_settle_chk
        $error("SETTLE_CYCLES must be >= 3 to cover synchroniser latency");
    end
    if (SAMPLE_CYCLES < 1) begin : g_sample_chk
        $error("SAMPLE_CYCLES must be >= 1");
    end

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [VEC_W-1:0]       vec;
    logic [NUM_VECTORS-1:0] exp_q;
    logic                   synced;
    logic                   prev;
    logic                   chg;
    logic [NUM_VECTORS-1:0] result_nxt;
    logic [NUM_VECTORS-1:0] unstable_nxt;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (dut_out),
        .q    (synced)
    );

    // edge detect inside the window (first sample is only the reference) and next-value views
    always_comb begin
        chg = (state == SAMPLE) && (cnt != '0) && (synced != prev);
        result_nxt = result;
        result_nxt[vec] = synced;
        unstable_nxt = unstable | (NUM_VECTORS'(chg) << vec);
    end

    // evaluation sequencer: settle then sample each vector, finish with a one-cycle done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            vec      <= '0;
            exp_q    <= '0;
            prev     <= 1'b0;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            unstable <= '0;
            pass     <= 1'b0;
        end else begin
            prev <= synced;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETTLE;
                        cnt      <= '0;
                        vec      <= '0;
                        exp_q    <= expected;
                        dut_in   <= '0;
                        busy     <= 1'b1;
                        result   <= '0;
                        unstable <= '0;
                        pass     <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt   <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                    state <= (cnt == SETTLE_LAST) ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    unstable <= unstable_nxt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == SAMPLE_LAST) begin
                        cnt    <= '0;
                        result <= result_nxt;
                        if (vec == VEC_LAST) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            dut_in <= '0;
                            pass   <= (result_nxt == exp_q) && (unstable_nxt == '0);
                        end else begin
                            state  <= SETTLE;
                            vec    <= vec + 1'b1;
                            dut_in <= vec + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CIRCUIT_EVAL_TOGGLE_CNT_EN
    // saturating count of synced output edges seen inside sample windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            toggle_count <= '0;
        else if (state == IDLE && start)
            toggle_count <= '0;
        else if (chg && toggle_count != '1)
            toggle_count <= toggle_count + 1'b1;
    end
`else
    assign toggle_count = '0;
`endif

endmodule

// File: tb/tb_circuit_eval.sv
// tb_circuit_eval: randomized scoreboard bench for circuit_eval with a behavioural evolved-circuit model
module tb_circuit_eval;

    localparam int S = 16;
    localparam int W = 64;
    localparam int RUN = 4 * (S + W);
`ifdef CIRCUIT_EVAL_TOGGLE_CNT_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] result;
        logic [3:0] rmask;
        logic [3:0] unstable;
        logic       pass;
        int         tc;
        int         done_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic [3:0] expected = 4'b0;
    logic [1:0] dut_in, dut_in4;
    logic       dut_out;
    logic       busy, done, pass, busy4, done4, pass4;
    logic [3:0] result, unstable, result4, unstable4;
    logic [7:0] toggle_count;
    logic [3:0] toggle_count4;

    logic [3:0] fn = 4'b0;
    logic [3:0] mask = 4'b0;
    int         period = 1;
    logic       osc = 1'b0;
    int         oc = 0;
    int         ecnt = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    exp_t       q4[$];

    circuit_eval #(.SETTLE_CYCLES(S), .SAMPLE_CYCLES(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_in(dut_in),
        .dut_out(dut_out), .busy(busy), .done(done), .result(result), .unstable(unstable),
        .pass(pass), .toggle_count(toggle_count)
    );

    circuit_eval #(.SETTLE_CYCLES(S), .SAMPLE_CYCLES(W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(expected), .dut_in(dut_in4),
        .dut_out(dut_out), .busy(busy4), .done(done4), .result(result4), .unstable(unstable4),
        .pass(pass4), .toggle_count(toggle_count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt++;

    // evolved-circuit model: truth table fn, inputs listed in mask oscillate every period clocks
    always @(negedge clk) begin
        oc++;
        if (oc >= period) begin
            oc = 0;
            osc = ~osc;
        end
    end
    assign dut_out = mask[dut_in] ? osc : fn[dut_in];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t predict(input logic [3:0] f, m, ev, input int per, cmax, base);
        exp_t e;
        int n;
        n = $countones(m) * ((W - 1) / per);
        e.rmask = ~m;
        e.result = f & ~m;
        e.unstable = m;
        e.pass = (m == 4'b0) && (f == ev);
        e.tc = TC_EN ? ((n > cmax) ? cmax : n) : 0;
        e.done_edge = base + 1 + RUN;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [3:0] r, u, input logic p,
                           input int tc, input logic b, input logic [1:0] di);
        if (e.rmask != 4'b0) chk({tag, " result"}, int'(r & e.rmask), int'(e.result & e.rmask));
        chk({tag, " unstable"}, int'(u), int'(e.unstable));
        chk({tag, " pass"}, int'(p), int'(e.pass));
        chk({tag, " toggle_count"}, tc, e.tc);
        chk({tag, " done_cycle"}, ecnt, e.done_edge);
        chk({tag, " busy_at_done"}, int'(b), 1);
        chk({tag, " dut_in_at_done"}, int'(di), 0);
    endtask

    // monitor for the main instance: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) chk("spurious_done", int'(done), 0);
            else compare("run", q.pop_front(), result, unstable, pass, int'(toggle_count), busy, dut_in);
        end
    end

    // monitor for the narrow-counter instance
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) chk("spurious_done4", int'(done4), 0);
            else compare("cnt4", q4.pop_front(), result4, unstable4, pass4, int'(toggle_count4), busy4, dut_in4);
        end
    end

    task automatic wait_done(input bit use4);
        int n = 0;
        while (!(use4 ? done4 : done) && n < RUN + 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= RUN + 50) chk("done_timeout", int'(use4 ? done4 : done), 1);
    endtask

    task automatic run(input logic [3:0] f, m, ev, input int per);
        fn = f;
        mask = m;
        period = per;
        expected = ev;
        @(negedge clk);
        q.push_back(predict(f, m, ev, per, 255, ecnt));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        logic [3:0] f, m, ev;
        repeat (3) @(negedge clk);
        chk("reset dut_in", int'(dut_in), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset unstable", int'(unstable), 0);
        chk("reset pass", int'(pass), 0);
        chk("reset toggle_count", int'(toggle_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(4'b0110, 4'b0000, 4'b0110, 1);
        run(4'b1111, 4'b0000, 4'b0110, 1);
        run(4'b0110, 4'b0100, 4'b0110, 3);

        fn = 4'b0110; mask = 4'b0; expected = 4'b0110;
        @(negedge clk);
        q.push_back(predict(fn, mask, expected, 1, 255, ecnt));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("start_ignored busy", int'(busy), 0);

        fn = 4'b1001; expected = 4'b1001;
        @(negedge clk);
        e1 = predict(fn, mask, expected, 1, 255, ecnt);
        e2 = e1;
        e2.done_edge = e1.done_edge + 2 + RUN;
        q.push_back(e1);
        q.push_back(e2);
        start = 1'b1;
        wait_done(0);
        @(negedge clk);
        chk("held gap busy", int'(busy), 0);
        @(negedge clk);
        chk("held rerun busy", int'(busy), 1);
        wait_done(0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        fn = 4'b1111; expected = 4'b0110;
        @(negedge clk);
        q.push_back(predict(fn, mask, expected, 1, 255, ecnt));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (105) @(negedge clk);
        chk("pre_reset dut_in", int'(dut_in), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset dut_in", int'(dut_in), 0);
        chk("midrun reset busy", int'(busy), 0);
        chk("midrun reset done", int'(done), 0);
        chk("midrun reset result", int'(result), 0);
        chk("midrun reset unstable", int'(unstable), 0);
        chk("midrun reset pass", int'(pass), 0);
        void'(q.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (RUN) @(negedge clk);
        run(4'b0110, 4'b0000, 4'b0110, 1);

        for (int i = 0; i < 6; i++) begin
            f = 4'($urandom);
            ev = $urandom_range(0, 1) ? f : 4'($urandom);
            m = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            run(f, m, ev, $urandom_range(0, 1) ? 1 : 3);
        end

        mask = 4'b1111; period = 1;
        @(negedge clk);
        q4.push_back(predict(fn, mask, expected, 1, 15, ecnt));
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(1);
        @(negedge clk);

        chk("scoreboard_empty", q.size() + q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
